// File: rtl/fpu_sched_pkg.sv
// Shared types for the FP IP sharing scheduler: requester id, in-flight tag and
// the round-robin pointer reset value.
package fpu_sched_pkg;

    localparam int WIDTH_DEF = 32;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    localparam req_id_t RR_PTR_RST = 1'b0;

endpackage

// File: rtl/fpu_tag_pipe.sv
// Shift register of in-flight tags that tracks operations through the FP IP.
// Exposes the oldest tag and whether any stage holds a live tag.
module fpu_tag_pipe
    import fpu_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t tag_p [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | tag_p[i].valid;
    end

    assign tag_out = tag_p[DEPTH-1];

endmodule

// File: rtl/fpu_share_sched.sv
// Round-robin sharing of one fixed-latency pipelined FP IP between two
// requesters, with per-requester in-flight limits and tagged result steering.
module fpu_share_sched
    import fpu_sched_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LAT     = 7,
    parameter int MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res0_valid,
    output logic [WIDTH-1:0] res0_data,
    output logic             res1_valid,
    output logic [WIDTH-1:0] res1_data,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    input  logic [WIDTH-1:0] fpu_res,
    output logic             busy
);

    localparam int                 CNT_W   = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] out_cnt0, out_cnt1;
    req_id_t          rr_ptr;
    logic             elig0, elig1, acc0, acc1, ret0, ret1, pipe_busy;
    tag_t             tag_in, tag_out;

    // Arbitration: counters and pointer are registered, so a retire in the
    // same cycle never frees a slot early.
    assign elig0      = req0_valid && (out_cnt0 < CNT_MAX);
    assign elig1      = req1_valid && (out_cnt1 < CNT_MAX);
    assign req0_ready = rst_n && elig0 && (!elig1 || rr_ptr == 1'b0);
    assign req1_ready = rst_n && elig1 && (!elig0 || rr_ptr == 1'b1);
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;

    assign tag_in = '{valid: acc0 | acc1, id: acc1};

    // One extra stage covers the operand register in front of the IP.
    fpu_tag_pipe #(.DEPTH(LAT + 1)) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .tag_in   (tag_in),
        .tag_out  (tag_out),
        .any_valid(pipe_busy)
    );

    assign ret0       = tag_out.valid && (tag_out.id == 1'b0);
    assign ret1       = tag_out.valid && (tag_out.id == 1'b1);
    assign res0_valid = ret0;
    assign res1_valid = ret1;
    assign res0_data  = ret0 ? fpu_res : '0;
    assign res1_data  = ret1 ? fpu_res : '0;
    assign busy       = pipe_busy || (out_cnt0 != '0) || (out_cnt1 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_a    <= '0;
            fpu_b    <= '0;
            rr_ptr   <= RR_PTR_RST;
            out_cnt0 <= '0;
            out_cnt1 <= '0;
        end else begin
            // Idle cycles feed 0+0 so the IP never sees stale operands.
            fpu_a <= acc0 ? req0_a : (acc1 ? req1_a : '0);
            fpu_b <= acc0 ? req0_b : (acc1 ? req1_b : '0);
            if (acc0)      rr_ptr <= 1'b1;
            else if (acc1) rr_ptr <= 1'b0;
            case ({acc0, ret0})
                2'b10:   out_cnt0 <= out_cnt0 + CNT_ONE;
                2'b01:   out_cnt0 <= out_cnt0 - CNT_ONE;
                default: out_cnt0 <= out_cnt0;
            endcase
            case ({acc1, ret1})
                2'b10:   out_cnt1 <= out_cnt1 + CNT_ONE;
                2'b01:   out_cnt1 <= out_cnt1 - CNT_ONE;
                default: out_cnt1 <= out_cnt1;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_share_sched.sv
// Bench for fpu_share_sched: IP model, result scoreboard, table-driven
// arbitration vectors and hand-written multi-cycle sequences.
module tb_fpu_share_sched;

    localparam int LAT     = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res0_valid, res1_valid, busy;
    logic [31:0] res0_data, res1_data, fpu_a, fpu_b, fpu_res;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        logic        r0, r1;
    } vec_t;
    vec_t tbl[7];

    fpu_share_sched #(.WIDTH(32), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_data(res1_data),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_res(fpu_res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ipf(input logic [31:0] a, input logic [31:0] b);
        return (a + {b[15:0], b[31:16]}) ^ 32'h5A5A_0F0F;
    endfunction

    // Fixed-latency IP model: value presented on fpu_a/fpu_b appears LAT cycles later.
    logic [31:0] ipq [LAT];
    always @(posedge clk) begin
        ipq[0] <= ipf(fpu_a, fpu_b);
        for (int i = 1; i < LAT; i++) ipq[i] <= ipq[i-1];
    end
    assign fpu_res = ipq[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result monitor, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (res0_valid || res1_valid) begin
                if (sbq.size() == 0) begin
                    chk("res_unexpected", {30'd0, res1_valid, res0_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_id", {30'd0, res1_valid, res0_valid}, e.id ? 32'd2 : 32'd1);
                    chk("res_data", e.id ? res1_data : res0_data, e.data);
                    chk("res_other_data", e.id ? res0_data : res1_data, 32'd0);
                    chk("res_cycle", cyc, e.cyc);
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                chk("res_missing", {30'd0, res1_valid, res0_valid}, e.id ? 32'd2 : 32'd1);
            end
        end
    end

    // Drive one cycle; entered and left at posedge+1.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit do_chk, input logic e0, input logic e1, input string nm);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        if (do_chk) begin
            chk({nm, "_ready0"}, {31'd0, req0_ready}, {31'd0, e0});
            chk({nm, "_ready1"}, {31'd0, req1_ready}, {31'd0, e1});
        end
        if (req0_valid && req0_ready) sbq.push_back('{id: 1'b0, data: ipf(a0, b0), cyc: cyc + 1 + LAT});
        if (req1_valid && req1_ready) sbq.push_back('{id: 1'b1, data: ipf(a1, b1), cyc: cyc + 1 + LAT});
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 1, 0};
        tbl[1] = '{1, 1, 32'hBF80_0000, 32'h7F80_0000, 32'h0000_0001, 32'h8000_0000, 0, 1};
        tbl[2] = '{0, 1, 32'h1111_1111, 32'h2222_2222, 32'h7FC0_0000, 32'h3F00_0000, 0, 1};
        tbl[3] = '{1, 1, 32'hC120_0000, 32'h4120_0000, 32'h0080_0000, 32'h0000_FFFF, 1, 0};
        tbl[4] = '{1, 0, 32'hFF7F_FFFF, 32'h7F7F_FFFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 0};
        tbl[5] = '{1, 1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 32'hAAAA_5555, 0, 1};
        tbl[6] = '{0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0};

        // Reset state, with a request pending to show ready is held low.
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h40C9_9999; req0_b = 32'h40C9_9999;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        #12;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_fpu_a", fpu_a, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Single op from requester 0.
        step(1, 32'h40C9_9999, 32'h40C9_9999, 0, 0, 0, 1, 1, 0, "t1");
        req0_valid = 1'b0;
        chk("t1_fpu_a", fpu_a, 32'h40C9_9999);
        chk("t1_fpu_b", fpu_b, 32'h40C9_9999);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        idle(LAT + 3);

        // Both requesters every cycle: strict alternation, requester 1 first.
        for (int k = 0; k < 20; k++)
            step(1, 32'h1000_0000 + k, 32'h0000_0100 * k, 1, 32'h2000_0000 + k, 32'hF000_000F ^ k,
                 1, (k % 2) == 1, (k % 2) == 0, "t2");
        idle(LAT + 3);

        // In-flight limit on requester 0, no same-cycle bypass on retire.
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h4200_0000 + k, 32'h3E00_0000 + k, 0, 0, 0,
                 1, (k != 2) && (k != 3), 0, "t3");
            if (k == 4) begin
                chk("t5_cnt0_held", {29'd0, dut.out_cnt0}, 32'd1);
                chk("t5_busy", {31'd0, busy}, 32'd1);
            end
        end
        idle(LAT + 3);

        // Reset with three ops in flight.
        step(1, 32'h3F00_0001, 32'h3F00_0002, 1, 32'h3F00_0003, 32'h3F00_0004, 1, 0, 1, "t4");
        step(1, 32'h3F00_0001, 32'h3F00_0002, 1, 32'h3F00_0005, 32'h3F00_0006, 1, 1, 0, "t4");
        step(1, 32'h3F00_0007, 32'h3F00_0008, 1, 32'h3F00_0009, 32'h3F00_000A, 1, 0, 1, "t4");
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("t4_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("t4_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
        chk("t4_res_data", res0_data | res1_data, 32'd0);
        chk("t4_fpu_a", fpu_a | fpu_b, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            chk("t4_no_pulse", {30'd0, res1_valid, res0_valid}, 32'd0);
            chk("t4_busy_after", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;

        // Table vectors, pointer starts at requester 0 after reset.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1,
                 1, tbl[i].r0, tbl[i].r1, "tbl");
            idle(LAT + 2);
        end

        // Long idle.
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 0, 1, 0, 0, "t6");
            chk("t6_fpu", fpu_a | fpu_b, 32'd0);
            chk("t6_busy", {31'd0, busy}, 32'd0);
            chk("t6_res_valid", {30'd0, res1_valid, res0_valid}, 32'd0);
        end

        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
